// File: rtl/result_pack_out_ctrl_pkg.sv
// Shared widths, state encoding and batch sizing for the
// mul_tree_bf16 result return path.
package result_pack_out_ctrl_pkg;

  localparam int IN_WIDTH   = 128;
  localparam int OUT_WIDTH  = 256;
  localparam int ADDR_WIDTH = 10;
  localparam int DEPTH      = 1024;
  localparam int CNT_W      = ADDR_WIDTH + 2;
  localparam int PTR_W      = ADDR_WIDTH + 1;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  // Results per batch; also used by the input controller's stop logic
  function automatic logic [CNT_W-1:0] target_count(
    input logic [1:0] m
  );
    unique case (m)
      2'd0:    return CNT_W'(512);
      2'd3:    return CNT_W'(2048);
      default: return CNT_W'(1024);
    endcase
  endfunction

endpackage

// File: rtl/result_pack_out_ctrl_bram.sv
// Simple dual-port BRAM, one write and one registered read
// port; rd_data_vld marks data returned one cycle after re.
module result_pack_out_ctrl_bram #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_vld,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_vld <= 1'b0;
    else        rd_data_vld <= re;
  end

endmodule

// File: rtl/result_pack_out_ctrl.sv
// Packs 128-bit result pairs into an output BRAM and drains
// each completed batch to the host over a valid/ready stream.
module result_pack_out_ctrl
  import result_pack_out_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  res_in,
  input  logic                 res_vld,
  input  logic [1:0]           mode,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_vld,
  input  logic                 out_ready,
  output logic [1:0]           state,
  output logic                 done,
  output logic                 overflow
);

  logic [1:0]            mode_q;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      tgt;
  logic [PTR_W-1:0]      words;
  logic                  half;
  logic [IN_WIDTH-1:0]   hold_q;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      pop_cnt;

  logic                  st_col;
  logic                  st_drn;
  logic                  st_dne;
  logic                  acc;
  logic                  last_res;
  logic                  we;
  logic [OUT_WIDTH-1:0]  wr_data;

  logic                  re;
  logic [OUT_WIDTH-1:0]  rd_data;
  logic                  rd_data_vld;
  logic                  pop;
  logic                  last_pop;
  logic [1:0]            level;
  logic [1:0]            lvl_next;

  logic                  skid_vld;
  logic [OUT_WIDTH-1:0]  skid_data;

  assign st_col   = state == ST_COLLECT;
  assign st_drn   = state == ST_DRAIN;
  assign st_dne   = state == ST_DONE;

  assign tgt      = target_count(mode_q);
  assign words    = PTR_W'(tgt >> 1);

  assign acc      = st_col & res_vld;
  assign last_res = acc & (cnt + CNT_W'(1) == tgt);
  assign we       = acc & half;
  assign wr_data  = {hold_q, res_in};

  assign pop      = out_vld & out_ready;
  assign last_pop = pop & (pop_cnt == words - PTR_W'(1));

  // Occupancy after this cycle's pop, counting the read in flight
  assign level    = {1'b0, out_vld} + {1'b0, skid_vld}
                  + {1'b0, rd_data_vld};
  assign lvl_next = level - {1'b0, pop};
  assign re       = st_drn & (rd_ptr != words)
                  & (lvl_next < 2'd2);

  result_pack_out_ctrl_bram #(
    .DATA_WIDTH (OUT_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bram (
    .clk         (clk),
    .rst_n       (rst_n),
    .re          (re),
    .rd_addr     (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data     (rd_data),
    .rd_data_vld (rd_data_vld),
    .we          (we),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_COLLECT;
      mode_q   <= 2'd0;
      cnt      <= '0;
      half     <= 1'b0;
      hold_q   <= '0;
      wr_addr  <= '0;
      rd_ptr   <= '0;
      pop_cnt  <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (res_vld && !st_col) overflow <= 1'b1;
      if (re)  rd_ptr  <= rd_ptr + PTR_W'(1);
      if (pop) pop_cnt <= pop_cnt + PTR_W'(1);
      unique case (1'b1)
        st_col: begin
          if (acc) begin
            if (cnt == '0) mode_q <= mode;
            if (!half) hold_q <= res_in;
            half <= ~half;
            if (last_res) begin
              state   <= ST_DRAIN;
              cnt     <= '0;
              wr_addr <= '0;
              half    <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
              if (half) wr_addr <= wr_addr + ADDR_WIDTH'(1);
            end
          end
        end
        st_drn: begin
          if (last_pop) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        st_dne: begin
          state   <= ST_COLLECT;
          rd_ptr  <= '0;
          pop_cnt <= '0;
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

  // Output register backed by a skid entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld   <= 1'b0;
      out_data  <= '0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
    end else if (!out_vld || out_ready) begin
      if (skid_vld) begin
        out_vld  <= 1'b1;
        out_data <= skid_data;
        skid_vld <= rd_data_vld;
        if (rd_data_vld) skid_data <= rd_data;
      end else begin
        out_vld <= rd_data_vld;
        if (rd_data_vld) out_data <= rd_data;
      end
    end else if (rd_data_vld) begin
      skid_vld  <= 1'b1;
      skid_data <= rd_data;
    end
  end

endmodule

// File: tb/tb_result_pack_out_ctrl.sv
// Directed batch table plus reset/stall/overflow sequences
// for result_pack_out_ctrl.
module tb_result_pack_out_ctrl;
  import result_pack_out_ctrl_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [IN_WIDTH-1:0]  res_in = '0;
  logic                 res_vld = 1'b0;
  logic [1:0]           mode = 2'd0;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_vld;
  logic                 out_ready = 1'b0;
  logic [1:0]           state;
  logic                 done;
  logic                 overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  result_pack_out_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_in    (res_in),
    .res_vld   (res_vld),
    .mode      (mode),
    .out_data  (out_data),
    .out_vld   (out_vld),
    .out_ready (out_ready),
    .state     (state),
    .done      (done),
    .overflow  (overflow)
  );

  typedef struct {
    int         tag;
    logic [1:0] m0;
    logic [1:0] m1;
    bit         rnd;
    int         stall;
    bit         inj;
    int         words;
    bit         ovf;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [IN_WIDTH-1:0] r(int tag, int i);
    return {32'(tag), 32'(i), ~32'(i), 32'hC0DE_0000 + 32'(i)};
  endfunction

  function automatic logic [OUT_WIDTH-1:0] exp_word(
    int tag, int k
  );
    return {r(tag, 2 * k), r(tag, 2 * k + 1)};
  endfunction

  task automatic chk(string nm, logic [255:0] act,
                     logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(int tag, logic [1:0] m0, logic [1:0] m1,
                      int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == n - 1) chk("collect_hold", 256'(state),
                          256'(ST_COLLECT));
      res_vld = 1'b1;
      res_in  = r(tag, i);
      mode    = (i < n / 2) ? m0 : m1;
    end
    @(posedge clk); #1;
    res_vld = 1'b0;
    res_in  = '0;
    chk("drain_entry", 256'(state), 256'(ST_DRAIN));
  endtask

  task automatic drain(int tag, int nw, bit rnd, int stall,
                       bit inj);
    int k = 0;
    int cyc = 0;
    int gaps = 0;
    int first = 0;
    bit prev_stall = 1'b0;
    bit rdy;
    logic [OUT_WIDTH-1:0] prev = '0;
    while (k < nw && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (prev_stall) begin
        chk("stall_vld", 256'(out_vld), 256'(1));
        chk("stall_data", out_data, prev);
      end
      if (stall > 0 && cyc == stall) begin
        chk("hold_word0_vld", 256'(out_vld), 256'(1));
        chk("hold_word0", out_data, exp_word(tag, 0));
      end
      if (out_vld && first == 0) first = cyc;
      if (!out_vld && first != 0) gaps++;
      if (cyc <= stall) rdy = 1'b0;
      else if (rnd)     rdy = 1'($urandom_range(1, 0));
      else              rdy = 1'b1;
      out_ready = rdy;
      res_vld   = inj && (cyc % 7 == 3);
      res_in    = {4{32'hDEAD_BEEF}};
      if (out_vld && rdy) begin
        chk("word", out_data, exp_word(tag, k));
        k++;
      end
      prev_stall = out_vld && !rdy;
      prev       = out_data;
    end
    res_vld = 1'b0;
    res_in  = '0;
    chk("drain_words", 256'(k), 256'(nw));
    if (stall == 0)
      chk("first_vld_latency", 256'(first >= 1 && first <= 3),
          256'(1));
    if (!rnd && stall == 0)
      chk("back_to_back", 256'(gaps), 256'(0));
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("done_pulse", 256'(done), 256'(1));
    chk("state_done", 256'(state), 256'(ST_DONE));
    chk("done_vld_low", 256'(out_vld), 256'(0));
    @(posedge clk); #1;
    chk("done_clear", 256'(done), 256'(0));
    chk("state_rearm", 256'(state), 256'(ST_COLLECT));
  endtask

  initial begin
    vecs[0] = '{1, 2'd0, 2'd0, 1'b0, 0,   1'b0, 256,  1'b0};
    vecs[1] = '{2, 2'd3, 2'd3, 1'b1, 0,   1'b0, 1024, 1'b0};
    vecs[2] = '{3, 2'd0, 2'd0, 1'b0, 100, 1'b0, 256,  1'b0};
    vecs[3] = '{4, 2'd0, 2'd0, 1'b0, 0,   1'b1, 256,  1'b1};
    vecs[4] = '{5, 2'd1, 2'd1, 1'b0, 0,   1'b0, 512,  1'b1};
    vecs[5] = '{6, 2'd3, 2'd0, 1'b0, 0,   1'b0, 1024, 1'b1};

    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", 256'(state), 256'(ST_COLLECT));
    chk("rst_vld", 256'(out_vld), 256'(0));
    chk("rst_data", out_data, '0);
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_ovf", 256'(overflow), 256'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      send(vecs[v].tag, vecs[v].m0, vecs[v].m1,
           2 * vecs[v].words);
      drain(vecs[v].tag, vecs[v].words, vecs[v].rnd,
            vecs[v].stall, vecs[v].inj);
      chk("overflow", 256'(overflow), 256'(vecs[v].ovf));
    end

    // Reset in the middle of a drain abandons the batch
    send(7, 2'd0, 2'd0, 512);
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      res_vld = (i == 4);
    end
    res_vld = 1'b0;
    chk("mid_drain_vld", 256'(out_vld), 256'(1));
    chk("mid_drain_state", 256'(state), 256'(ST_DRAIN));
    rst_n = 1'b0;
    #1;
    chk("async_rst_vld", 256'(out_vld), 256'(0));
    chk("async_rst_state", 256'(state), 256'(ST_COLLECT));
    chk("async_rst_ovf", 256'(overflow), 256'(0));
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8, 2'd2, 2'd2, 1024);
    drain(8, 512, 1'b0, 0, 1'b0);
    chk("post_rst_ovf", 256'(overflow), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
